mem_access_unit: RTL and testbench

Sequential memory-access unit between the multicycle datapath and a single-port synchronous word RAM. It maps RISC-V byte addresses in the .text and .data regions onto a unified RAM word index. It performs lb/lh/lw/lbu/lhu loads with lane extraction and extension, sw stores directly, and sb/sh stores as read-modify-write. The datapath issues one request and holds it until a one-cycle oReady pulse.

---
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Handshake bundle between the datapath, the memory-access unit and the RAM.
// master: datapath/RAM side; slave: the memory-access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 11
);
  logic              iReq;
  logic              iWrite;
  logic [2:0]        iFunct3;
  logic [31:0]       iAddress;
  logic [31:0]       iData;
  logic              oReady;
  logic              oFault;
  logic [31:0]       oData;
  logic [31:0]       oAddressMapped;
  logic [ADDR_W-1:0] mAddr;
  logic              mWe;
  logic [31:0]       mWdata;
  logic [31:0]       mRdata;

  modport master (
    output iReq, iWrite, iFunct3, iAddress, iData, mRdata,
    input  oReady, oFault, oData, oAddressMapped,
    input  mAddr, mWe, mWdata
  );

  modport slave (
    input  iReq, iWrite, iFunct3, iAddress, iData, mRdata,
    output oReady, oFault, oData, oAddressMapped,
    output mAddr, mWe, mWdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit mapping .text/.data byte addresses onto one word RAM.
// Ports: clock, reset (sync, active low), bus (request side + RAM side).
module mem_access_unit #(
  parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
  parameter int          TEXT_WORDS = 1024,
  parameter int          DATA_WORDS = 1024,
  parameter int          ADDR_W     = 11
) (
  input logic              clock,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, LATCH, WR, DONE} state_t;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  localparam logic [31:0] TEXT_END = TEXT_BASE + 32'(4 * TEXT_WORDS);
  localparam logic [31:0] DATA_END = DATA_BASE + 32'(4 * DATA_WORDS);
  localparam logic [29:0] TEXT_W0  = TEXT_BASE[31:2];
  // data words follow the text words in RAM
  localparam logic [29:0] DATA_W0  = DATA_BASE[31:2] - 30'(TEXT_WORDS);

  state_t      state;
  logic        write_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] half_q;
  logic        fault_q;

  logic        in_text, in_data, fault;
  logic        is_b, is_h, is_w, is_bu, is_hu;
  logic [29:0] word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v, merge_v;

  always_comb begin
    in_text = (bus.iAddress >= TEXT_BASE) && (bus.iAddress < TEXT_END);
    in_data = (bus.iAddress >= DATA_BASE) && (bus.iAddress < DATA_END);
    word    = '0;
    if (in_text)      word = bus.iAddress[31:2] - TEXT_W0;
    else if (in_data) word = bus.iAddress[31:2] - DATA_W0;
    is_b  = bus.iFunct3 == F_B;
    is_h  = bus.iFunct3 == F_H;
    is_w  = bus.iFunct3 == F_W;
    is_bu = bus.iFunct3 == F_BU;
    is_hu = bus.iFunct3 == F_HU;
    fault = !(in_text || in_data)
          || !(is_b || is_h || is_w || is_bu || is_hu)
          || ((is_h || is_hu) && bus.iAddress[0])
          || (is_w && (bus.iAddress[1:0] != 2'b00))
          || (bus.iWrite && (is_bu || is_hu));
  end

  always_comb begin
    byte_v = bus.mRdata[7:0];
    unique case (lane_q)
      2'd0: byte_v = bus.mRdata[7:0];
      2'd1: byte_v = bus.mRdata[15:8];
      2'd2: byte_v = bus.mRdata[23:16];
      2'd3: byte_v = bus.mRdata[31:24];
    endcase
    half_v = lane_q[1] ? bus.mRdata[31:16] : bus.mRdata[15:0];
    load_v = bus.mRdata;
    unique case (1'b1)
      f3_q == F_B:  load_v = {{24{byte_v[7]}}, byte_v};
      f3_q == F_H:  load_v = {{16{half_v[15]}}, half_v};
      f3_q == F_BU: load_v = {24'd0, byte_v};
      f3_q == F_HU: load_v = {16'd0, half_v};
      default:      load_v = bus.mRdata;
    endcase
    merge_v = bus.mRdata;
    if (f3_q == F_B) begin
      unique case (lane_q)
        2'd0: merge_v[7:0]   = half_q[7:0];
        2'd1: merge_v[15:8]  = half_q[7:0];
        2'd2: merge_v[23:16] = half_q[7:0];
        2'd3: merge_v[31:24] = half_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merge_v[31:16] = half_q;
    end else begin
      merge_v[15:0] = half_q;
    end
  end

  // a WR cycle under reset must not reach the RAM
  assign bus.mWe = (state == WR) && reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      write_q            <= 1'b0;
      f3_q               <= '0;
      lane_q             <= '0;
      half_q             <= '0;
      fault_q            <= 1'b0;
      bus.oReady         <= 1'b0;
      bus.oFault         <= 1'b0;
      bus.oData          <= '0;
      bus.oAddressMapped <= '0;
      bus.mAddr          <= '0;
      bus.mWdata         <= '0;
    end else begin
      bus.oReady <= 1'b0;
      bus.oFault <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.iReq) begin
            write_q            <= bus.iWrite;
            f3_q               <= bus.iFunct3;
            lane_q             <= bus.iAddress[1:0];
            half_q             <= bus.iData[15:0];
            fault_q            <= fault;
            bus.oAddressMapped <= {word, bus.iAddress[1:0]};
            if (fault) begin
              state      <= DONE;
              bus.oReady <= 1'b1;
              bus.oFault <= 1'b1;
            end else begin
              bus.mAddr <= word[ADDR_W-1:0];
              if (bus.iWrite && is_w) begin
                bus.mWdata <= bus.iData;
                state      <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= LATCH;
        LATCH: begin
          if (write_q) begin
            bus.mWdata <= merge_v;
            state      <= WR;
          end else begin
            bus.oData  <= load_v;
            bus.oReady <= 1'b1;
            state      <= DONE;
          end
        end
        WR: begin
          bus.oReady <= 1'b1;
          state      <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word RAM.
// Ports: none; drives the interface and checks with immediate assertions.
module tb_mem_access_unit;
  localparam int ADDR_W = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(
    .TEXT_BASE (32'h0040_0000),
    .DATA_BASE (32'h1001_0000),
    .TEXT_WORDS(1024),
    .DATA_WORDS(1024),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  logic [31:0]       ram [0:2047];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  always @(posedge clk) begin
    if (bus.mWe) ram[bus.mAddr] <= bus.mWdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
    bus.mRdata <= ram[bus.mAddr];
  end

  int vec = 0;
  int errs = 0;
  int lat, wes;
  logic [31:0] wd;
  logic [ADDR_W-1:0] wa, ra;
  logic flt;
  logic [31:0] held;

  logic        ft_w  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0]  ft_f3 [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
  logic [31:0] ft_a  [4] = '{32'h1001_0002, 32'h0040_0001,
                             32'h0000_0000, 32'h1001_0000};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  task automatic req(input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    bus.iWrite   = w;
    bus.iFunct3  = f3;
    bus.iAddress = a;
    bus.iData    = d;
    bus.iReq     = 1'b1;
    lat = 0; wes = 0; flt = 1'b0;
    wd = '0; wa = '0; ra = '0;
    while (lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) ra = bus.mAddr;
      if (bus.mWe) begin
        wes++;
        wd = bus.mWdata;
        wa = bus.mAddr;
      end
      if (bus.oReady) begin
        flt = bus.oFault;
        break;
      end
    end
    bus.iReq = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.iReq = 1'b0;
    bus.iWrite = 1'b0;
    bus.iFunct3 = 3'b000;
    bus.iAddress = '0;
    bus.iData = '0;
    rst_n = 1'b0;
    preload(11'd1024, 32'h8077_F0A1);
    @(posedge clk); #1;
    check("rst_ready", 32'(bus.oReady), 32'd0);
    check("rst_fault", 32'(bus.oFault), 32'd0);
    check("rst_data", bus.oData, 32'd0);
    check("rst_map", bus.oAddressMapped, 32'd0);
    check("rst_maddr", 32'(bus.mAddr), 32'd0);
    check("rst_wdata", bus.mWdata, 32'd0);
    check("rst_we", 32'(bus.mWe), 32'd0);
    rst_n = 1'b1;

    req(1'b0, 3'b000, 32'h1001_0000, 32'd0);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_flt", 32'(flt), 32'd0);
    check("lb_data", bus.oData, 32'hFFFF_FFA1);
    check("lb_map", bus.oAddressMapped, 32'h0000_1000);
    check("lb_maddr", 32'(ra), 32'd1024);

    req(1'b0, 3'b100, 32'h1001_0003, 32'd0);
    check("lbu_data", bus.oData, 32'h0000_0080);
    check("lbu_map", bus.oAddressMapped, 32'h0000_1003);

    req(1'b0, 3'b001, 32'h1001_0002, 32'd0);
    check("lh_lat", 32'(lat), 32'd3);
    check("lh_data", bus.oData, 32'hFFFF_8077);

    preload(11'd1024, 32'h1122_3344);
    req(1'b1, 3'b000, 32'h1001_0001, 32'h0000_00AB);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_flt", 32'(flt), 32'd0);
    check("sb_wes", 32'(wes), 32'd1);
    check("sb_wdata", wd, 32'h1122_AB44);
    check("sb_waddr", 32'(wa), 32'd1024);
    check("sb_odata", bus.oData, 32'hFFFF_8077);

    req(1'b0, 3'b010, 32'h1001_0000, 32'd0);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_data", bus.oData, 32'h1122_AB44);

    req(1'b0, 3'b101, 32'h1001_0002, 32'd0);
    check("lhu_data", bus.oData, 32'h0000_1122);

    req(1'b1, 3'b010, 32'h0040_0004, 32'hDEAD_BEEF);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_wes", 32'(wes), 32'd1);
    check("sw_waddr", 32'(wa), 32'd1);
    check("sw_wdata", wd, 32'hDEAD_BEEF);
    check("sw_ram", ram[1], 32'hDEAD_BEEF);

    held = 32'h0000_1122;
    for (int i = 0; i < 4; i++) begin
      req(ft_w[i], ft_f3[i], ft_a[i], 32'h5A5A_5A5A);
      check($sformatf("flt%0d_lat", i), 32'(lat), 32'd1);
      check($sformatf("flt%0d_flag", i), 32'(flt), 32'd1);
      check($sformatf("flt%0d_wes", i), 32'(wes), 32'd0);
      check($sformatf("flt%0d_data", i), bus.oData, held);
    end
    check("flt_ram", ram[1024], 32'h1122_AB44);

    req(1'b0, 3'b010, 32'h0040_0FFC, 32'd0);
    check("tend_flt", 32'(flt), 32'd0);
    check("tend_maddr", 32'(ra), 32'd1023);
    req(1'b0, 3'b010, 32'h0040_1000, 32'd0);
    check("tover_flt", 32'(flt), 32'd1);
    check("tover_lat", 32'(lat), 32'd1);
    req(1'b0, 3'b010, 32'h1001_0FFC, 32'd0);
    check("dend_flt", 32'(flt), 32'd0);
    check("dend_maddr", 32'(ra), 32'd2047);
    req(1'b0, 3'b010, 32'h1001_1000, 32'd0);
    check("dover_flt", 32'(flt), 32'd1);

    preload(11'd1025, 32'h5566_7788);
    bus.iWrite   = 1'b1;
    bus.iFunct3  = 3'b001;
    bus.iAddress = 32'h1001_0006;
    bus.iData    = 32'h0000_1234;
    bus.iReq     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rwr_we_pre", 32'(bus.mWe), 32'd1);
    rst_n    = 1'b0;
    bus.iReq = 1'b0;
    #1;
    check("rwr_we", 32'(bus.mWe), 32'd0);
    @(posedge clk); #1;
    check("rwr_ready", 32'(bus.oReady), 32'd0);
    check("rwr_data", bus.oData, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rwr_ready2", 32'(bus.oReady), 32'd0);
    check("rwr_ram", ram[1025], 32'h5566_7788);
    req(1'b0, 3'b010, 32'h1001_0004, 32'd0);
    check("rwr_lat", 32'(lat), 32'd3);
    check("rwr_load", bus.oData, 32'h5566_7788);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
